// File: rtl/kernel_pr_fifo_rr_arb_pkg.sv
// Shared definitions for the kernel_pr round-robin FIFO arbiter.
package kernel_pr_arb_defs;

  // Arbiter FSM states.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Width of the per-grant beat counter.
  localparam int BEAT_W = 8;

endpackage

// File: rtl/kernel_pr_fifo_rr_arb_pick.sv
// Rotating-priority picker: returns the first set request at or after
// i_start, wrapping modulo NUM_IN. Purely combinational.
module kernel_pr_rr_pick #(
  parameter int NUM_IN    = 4,
  parameter int SEL_WIDTH = 2
) (
  input  logic [NUM_IN-1:0]    i_req,
  input  logic [SEL_WIDTH-1:0] i_start,
  output logic                 o_found,
  output logic [SEL_WIDTH-1:0] o_index
);

  // One extra bit so start+offset cannot overflow before the modulo fold.
  logic [SEL_WIDTH:0]   w_sum;
  logic [SEL_WIDTH-1:0] w_idx;

  // Scan offsets 0..NUM_IN-1 from the start pointer; the first hit wins.
  always_comb begin
    o_found = 1'b0;
    o_index = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      w_sum = {1'b0, i_start} + (SEL_WIDTH+1)'(k);
      // Fold once; start < NUM_IN and k < NUM_IN keep the sum below 2*NUM_IN,
      // so a non-power-of-two NUM_IN never yields an out-of-range index.
      if (w_sum >= (SEL_WIDTH+1)'(NUM_IN)) begin
        w_sum = w_sum - (SEL_WIDTH+1)'(NUM_IN);
      end
      w_idx = w_sum[SEL_WIDTH-1:0];
      if (!o_found && i_req[w_idx]) begin
        o_found = 1'b1;
        o_index = w_idx;
      end
    end
  end

endmodule

// File: rtl/kernel_pr_fifo_rr_arb.sv
// Round-robin merge of NUM_IN upstream kernel_pr FIFOs into one downstream
// FIFO. Each grant lasts up to BURST_MAX beats or until the source drains;
// every release costs one IDLE arbitration cycle.
//
// Handshake: upstream head i is valid when in_empty_n[i] is high and is popped
// by in_read[i] in the same cycle; downstream accepts when out_full_n is high
// and is pushed by out_write. A beat moves only when the granted source is
// non-empty AND the sink is not full; in_read[grant] and out_write are that
// same combinational term, so a pop never happens without a push.
module kernel_pr_fifo_rr_arb
  import kernel_pr_arb_defs::*;
#(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 64,
  parameter int SEL_WIDTH  = 2,
  parameter int BURST_MAX  = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_IN-1:0]            in_empty_n,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_dout,
  output logic [NUM_IN-1:0]            in_read,
  input  logic                         out_full_n,
  output logic                         out_write,
  output logic [DATA_WIDTH-1:0]        out_din,
  output logic [SEL_WIDTH-1:0]         out_src,
  output logic                         busy,
  output logic                         dbg_state,
  output logic [SEL_WIDTH-1:0]         dbg_ptr
);

  localparam logic [BEAT_W-1:0]    LAST_BEAT = BEAT_W'(BURST_MAX - 1);
  localparam logic [SEL_WIDTH-1:0] LAST_IDX  = SEL_WIDTH'(NUM_IN - 1);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [SEL_WIDTH-1:0]  r_grant;
  logic [SEL_WIDTH-1:0]  w_grant_nxt;
  logic [SEL_WIDTH-1:0]  r_ptr;
  logic [SEL_WIDTH-1:0]  w_ptr_nxt;
  logic [BEAT_W-1:0]     r_beats;
  logic [BEAT_W-1:0]     w_beats_nxt;
  logic                  r_busy;

  logic                  w_found;
  logic [SEL_WIDTH-1:0]  w_pick;
  logic                  w_src_valid;
  logic                  w_xfer;
  logic [SEL_WIDTH-1:0]  w_grant_inc;
  logic [DATA_WIDTH-1:0] w_din;

  kernel_pr_rr_pick #(
    .NUM_IN    (NUM_IN),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_pick (
    .i_req   (in_empty_n),
    .i_start (r_ptr),
    .o_found (w_found),
    .o_index (w_pick)
  );

  assign w_src_valid = in_empty_n[r_grant];
  // Gated by reset_n so a mid-burst reset cycle neither pops nor pushes.
  assign w_xfer      = reset_n & (r_state == ST_GRANT) & w_src_valid & out_full_n;
  assign w_grant_inc = (r_grant == LAST_IDX) ? '0 : r_grant + 1'b1;

  // Pop strobe: only the granted input, only on a transfer.
  always_comb begin
    in_read = '0;
    if (w_xfer) begin
      in_read[r_grant] = 1'b1;
    end
  end

  // Data mux from the granted head; explicit compare keeps indices in range.
  always_comb begin
    w_din = in_dout[DATA_WIDTH-1:0];
    for (int i = 0; i < NUM_IN; i++) begin
      if (r_grant == SEL_WIDTH'(i)) begin
        w_din = in_dout[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign out_write = w_xfer;
  assign out_din   = w_din;
  assign out_src   = r_grant;
  assign busy      = r_busy;
  assign dbg_state = r_state;
  assign dbg_ptr   = r_ptr;

  // Next-state: arbitrate in IDLE; in GRANT count beats and decide release.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    w_beats_nxt = r_beats;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_GRANT;
          w_grant_nxt = w_pick;
          w_beats_nxt = '0;
        end
      end
      ST_GRANT: begin
        // Release on drained source (regardless of backpressure) or full burst.
        if (!w_src_valid || (w_xfer && (r_beats == LAST_BEAT))) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = w_grant_inc;
        end else if (w_xfer) begin
          w_beats_nxt = r_beats + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, grant, pointer and beat registers; busy mirrors the GRANT state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
      r_beats <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
      r_beats <= w_beats_nxt;
      r_busy  <= (w_state_nxt == ST_GRANT);
    end
  end

endmodule

// File: doc/kernel_pr_fifo_rr_arb.md
# kernel_pr_fifo_rr_arb

Round-robin arbiter that merges `NUM_IN` upstream 64-bit FIFO streams into one downstream FIFO, using the same `empty_n`/`read` and `full_n`/`write` handshakes as the kernel_pr FIFOs. It sits between the per-PE `kernel_pr_fifo_w64_d2_S` instances and the shared write-back FIFO, and tags each beat with its source index. A grant is held for a burst of up to `BURST_MAX` beats, so one stream cannot starve the others.

## Interface
- `NUM_IN`, 4: number of upstream FIFOs (2..16).
- `DATA_WIDTH`, 64: beat width.
- `SEL_WIDTH`, 2: index width, equal to clog2(`NUM_IN`).
- `BURST_MAX`, 8: maximum beats per grant (1..255).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `in_empty_n`  in  `NUM_IN`  upstream FIFO not-empty; the FIFO head is valid on `in_dout` when this is high.
- `in_dout`  in  `NUM_IN*DATA_WIDTH`  upstream heads; input i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `in_read`  out  `NUM_IN`  pop strobe; one-hot or zero.
- `out_full_n`  in  1  downstream FIFO not-full.
- `out_write`  out  1  push strobe.
- `out_din`  out  `DATA_WIDTH`  pushed beat.
- `out_src`  out  `SEL_WIDTH`  source index of the pushed beat.
- `busy`  out  1  high while a grant is held.

## Operation
- FSM with two states, IDLE and GRANT. Registers: `grant` (`SEL_WIDTH` bits), `ptr` (next search start), `beats` (8 bits).
- **IDLE:** search `in_empty_n` starting at `ptr` and wrapping modulo `NUM_IN`.
  - If any input is set, load `grant` with the first set index, clear `beats`, and go to GRANT.
  - If none is set, stay in IDLE.
- **GRANT:** the transfer condition is `xfer` = `in_empty_n[grant]` & `out_full_n`.
  - `in_read[grant]` = `out_write` = `xfer`, combinational pass-through.
  - `out_din` = the `in_dout` slice selected by `grant`.
  - `out_src` = `grant`.
- **Release** from GRANT to IDLE, with `ptr` set to (`grant`+1) mod `NUM_IN`, when either holds:
  - `xfer` and `beats` == `BURST_MAX`-1 (burst complete), or
  - `in_empty_n[grant]` == 0 (source drained), whether or not `out_full_n` is high.
- Otherwise `beats` increments on `xfer` and holds when `out_full_n` is low.
- **Backpressure:** while `out_full_n` is low, the grant is held indefinitely, no pop occurs, and `beats` is frozen.
- **Wrap-around:** `ptr` increments modulo `NUM_IN`. `ptr` == `NUM_IN`-1 wraps to 0; non-power-of-two `NUM_IN` must never produce an out-of-range index.
- `in_read` bits for non-granted inputs are always 0, and all `in_read` bits are 0 in IDLE.
- **Reset** (`reset_n` low at a rising edge) puts the block in IDLE with `grant`=0, `ptr`=0 and `beats`=0. Output reset values:
  - `in_read`=0, `out_write`=0, `busy`=0.
  - `out_src`=0; `out_din` = the input 0 slice.
  - Reset in mid-burst discards the grant. No pop or push occurs in the reset cycle.

## Timing
- Arbitration takes one IDLE cycle. The first beat of a grant transfers in the cycle after IDLE sees a non-empty input.
- After arbitration, throughput is one beat per cycle; transfer latency is 0 cycles (combinational from `in_dout` to `out_din`).
- Each release inserts exactly one IDLE bubble cycle before the next grant.
- With all inputs continuously non-empty and `out_full_n` high, the steady-state rate is `BURST_MAX` beats per `BURST_MAX`+1 cycles.
- `busy` is a registered version of state == GRANT.
- No combinational path from `out_full_n` to `in_empty_n` is required; the only paths are `out_full_n` to `in_read`/`out_write` and `in_empty_n` to `in_read`/`out_write`.

## Structure
- A shared package/header `kernel_pr_arb_defs` holds:
  - state encodings `ST_IDLE`=1'b0 and `ST_GRANT`=1'b1;
  - the beat-counter width, 8.
- One sub-module, `kernel_pr_rr_pick`: purely combinational rotating priority picker.
  - Inputs: request vector and start pointer.
  - Outputs: `found` and `index`.
  - Instantiated once in the IDLE path.
- The top level holds the FSM, counters, output mux and handshake logic.

## Test plan
- **Reset:** hold `reset_n` low for 3 cycles with all inputs non-empty.
  - Required: `in_read`=0, `out_write`=0, `busy`=0, `out_src`=0 throughout.
  - First grant goes to input 0 in the second cycle after release.
- **Burst limit:** `NUM_IN`=4, `BURST_MAX`=8, all inputs hold 20 beats, `out_full_n`=1.
  - Required grant order: 0, 1, 2, 3, 0, …, with exactly 8 beats per grant and one bubble cycle between grants.
  - `out_src` matches every beat, and data order within each source is preserved.
- **Drain-early release:** input 2 holds 3 beats; all other inputs are empty.
  - Required: 3 beats with `out_src`=2, then release, then `ptr`=3.
  - The next arrival at input 1 is granted after the search has wrapped past 3 and 0.
- **Backpressure:** drop `out_full_n` for 5 cycles in the middle of a burst, after beat 4.
  - Required: no `in_read`/`out_write` for those 5 cycles and the grant is held.
  - Exactly 4 more beats follow once `out_full_n` returns high.
- **Wrap-around:** only input 3 is active, with 2 beats.
  - Required: `ptr` wraps from 3 to 0 after release, and `in_read` only ever shows bit 3 set.
- **Reset mid-burst:** assert `reset_n` low after beat 3 of a grant to input 1.
  - Required: no pop in the reset cycle; after release, arbitration restarts from input 0.
